tiny_alu: RTL and testbench

- RTL responder for the tiny ALU start/done bus; it is the DUT that the tiny_alu BFM drives.
- On an accepted start, captures opcode and operands A/B, then computes the result.
  - Single-cycle ops: ADD, AND, XOR, NOP.
  - Multi-cycle op: MUL, sequenced by a small FSM.
- Returns the result with a one-cycle done pulse.
- Sits behind tiny_alu_bus_interface in the layered testbench; signal names match that bus.

---
 rtl/tiny_alu.sv | 123 ++++++++++++
 tb/tb_tiny_alu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tiny_alu.sv
// tiny_alu: start/done ALU responder. Single-cycle ADD/AND/XOR/NOP complete at the
// accept edge; MUL holds busy_o for MUL_LATENCY edges before its done pulse.
module tiny_alu #(
   parameter int INPUT_DATA_BITS = 8,
   parameter int OPCODE_BITS     = 3,
   parameter int MUL_LATENCY     = 3
) (
   input  logic                           clk_i,
   input  logic                           rst_n_i,
   input  logic                           start_i,
   input  logic [OPCODE_BITS-1:0]         opcode_i,
   input  logic [INPUT_DATA_BITS-1:0]     a_i,
   input  logic [INPUT_DATA_BITS-1:0]     b_i,
   output logic                           busy_o,
   output logic                           done_o,
   output logic [2*INPUT_DATA_BITS-1:0]   result_o
);

   localparam int RES_W = 2 * INPUT_DATA_BITS;
   localparam int CNT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;

   localparam logic [OPCODE_BITS-1:0] OP_ADD = OPCODE_BITS'(1);
   localparam logic [OPCODE_BITS-1:0] OP_AND = OPCODE_BITS'(2);
   localparam logic [OPCODE_BITS-1:0] OP_XOR = OPCODE_BITS'(3);
   localparam logic [OPCODE_BITS-1:0] OP_MUL = OPCODE_BITS'(4);

   typedef enum logic {
      IDLE,
      MUL_BUSY
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [CNT_W-1:0]           r_cnt;
   logic [OPCODE_BITS-1:0]     r_opcode;
   logic [INPUT_DATA_BITS-1:0] r_a;
   logic [INPUT_DATA_BITS-1:0] r_b;
   logic                       r_done;
   logic [RES_W-1:0]           r_result;

   logic                       w_accept;
   logic                       w_accept_mul;
   logic                       w_mul_last;
   logic [OPCODE_BITS-1:0]     w_op;
   logic [INPUT_DATA_BITS-1:0] w_a;
   logic [INPUT_DATA_BITS-1:0] w_b;
   logic [RES_W-1:0]           w_alu;

   assign w_accept     = start_i && (r_state == IDLE);
   assign w_accept_mul = w_accept && (opcode_i == OP_MUL);
   assign w_mul_last   = (r_state == MUL_BUSY) && (r_cnt == '0);

   // One shared ALU: live inputs while idle, captured operands while a MUL is in flight.
   assign w_op = (r_state == MUL_BUSY) ? r_opcode : opcode_i;
   assign w_a  = (r_state == MUL_BUSY) ? r_a      : a_i;
   assign w_b  = (r_state == MUL_BUSY) ? r_b      : b_i;

   always_comb begin
      w_alu = '0;
      case (w_op)
         OP_ADD:  w_alu = RES_W'(w_a) + RES_W'(w_b);
         OP_AND:  w_alu = RES_W'(w_a & w_b);
         OP_XOR:  w_alu = RES_W'(w_a ^ w_b);
         OP_MUL:  w_alu = RES_W'(w_a) * RES_W'(w_b);
         default: w_alu = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (w_accept_mul) w_state_nxt = MUL_BUSY;
         MUL_BUSY: if (w_mul_last)   w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_o   = (r_state == MUL_BUSY);
      done_o   = r_done;
      result_o = r_result;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cnt    <= '0;
         r_opcode <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_opcode <= opcode_i;
            r_a      <= a_i;
            r_b      <= b_i;
            if (w_accept_mul) begin
               r_cnt <= CNT_W'(MUL_LATENCY - 1);
            end else begin
               r_done   <= 1'b1;
               r_result <= w_alu;
            end
         end else if (r_state == MUL_BUSY) begin
            if (r_cnt == '0) begin
               r_done   <= 1'b1;
               r_result <= w_alu;
            end else begin
               r_cnt <= r_cnt - CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_tiny_alu.sv
// Bench for tiny_alu: directed scenarios plus random traffic, every cycle checked
// against a transaction-level model (remaining MUL edges + pending result).
module tb_tiny_alu;

   localparam int DW  = 8;
   localparam int OW  = 3;
   localparam int LAT = 3;
   localparam int RW  = 2 * DW;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [OW-1:0] op    = '0;
   logic [DW-1:0] a     = '0;
   logic [DW-1:0] b     = '0;
   logic          busy;
   logic          done;
   logic [RW-1:0] result;

   int n_checks = 0;
   int n_errors = 0;

   int          m_left = 0;
   int unsigned m_pend = 0;
   int unsigned m_res  = 0;
   bit          m_done = 1'b0;

   always #5 clk = ~clk;

   tiny_alu #(
      .INPUT_DATA_BITS(DW),
      .OPCODE_BITS    (OW),
      .MUL_LATENCY    (LAT)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .start_i (start),
      .opcode_i(op),
      .a_i     (a),
      .b_i     (b),
      .busy_o  (busy),
      .done_o  (done),
      .result_o(result)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned ref_op(input int unsigned o, input int unsigned x,
                                          input int unsigned y);
      case (o)
         1:       return x + y;
         2:       return x & y;
         3:       return x ^ y;
         4:       return x * y;
         default: return 0;
      endcase
   endfunction

   task automatic drive(input bit s, input int unsigned o, input int unsigned x,
                        input int unsigned y);
      start = s;
      op    = OW'(o);
      a     = DW'(x);
      b     = DW'(y);
   endtask

   task automatic model_reset();
      m_left = 0;
      m_done = 1'b0;
      m_res  = 0;
      m_pend = 0;
   endtask

   // Advance the model by one edge using the inputs presented now, then check the DUT.
   task automatic cycle();
      if (m_left > 0) begin
         m_left--;
         m_done = (m_left == 0);
         if (m_done) m_res = m_pend;
      end else if (start) begin
         if (op == 4) begin
            m_left = LAT;
            m_pend = ref_op(op, a, b);
            m_done = 1'b0;
         end else begin
            m_done = 1'b1;
            m_res  = ref_op(op, a, b);
         end
      end else begin
         m_done = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("done",   32'(done),   32'(m_done));
      chk("busy",   32'(busy),   32'(m_left > 0));
      chk("result", 32'(result), m_res);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_done",   32'(done),   0);
      chk("rst_busy",   32'(busy),   0);
      chk("rst_result", 32'(result), 0);
      rst_n = 1'b1;

      // ADD with carry out
      drive(1, 1, 'hFF, 'h01); cycle();
      chk("add_carry", 32'(result), 32'h0100);
      drive(0, 0, 0, 0);       cycle();

      // AND then XOR back-to-back
      drive(1, 2, 'hF0, 'h3C); cycle();
      chk("and_res", 32'(result), 32'h0030);
      drive(1, 3, 'hAA, 'h55); cycle();
      chk("xor_res",  32'(result), 32'h00FF);
      chk("xor_done", 32'(done),   1);
      drive(0, 0, 0, 0);       cycle();

      // MUL max operands
      drive(1, 4, 'hFF, 'hFF); cycle();
      drive(0, 1, 'h11, 'h22);
      repeat (LAT - 1) cycle();
      cycle();
      chk("mul_res", 32'(result), 32'hFE01);
      repeat (2) cycle();

      // ADD requested while MUL busy is ignored
      drive(1, 4, 'h03, 'h04); cycle();
      drive(1, 1, 'h01, 'h01); cycle(); cycle();
      drive(0, 0, 0, 0);       cycle();
      chk("mul_busy_res", 32'(result), 32'h000C);
      repeat (2) cycle();

      // Reserved opcode produces zero result with a done pulse
      drive(1, 6, 'h12, 'h34); cycle();
      chk("rsv_res",  32'(result), 0);
      chk("rsv_done", 32'(done),   1);
      drive(0, 0, 0, 0);       repeat (2) cycle();

      // Reset in mid-MUL cancels the operation
      drive(1, 4, 'h10, 'h10); cycle();
      drive(0, 0, 0, 0);       cycle();
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_done",   32'(done),   0);
      chk("midrst_busy",   32'(busy),   0);
      chk("midrst_result", 32'(result), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (LAT + 2) cycle();
      drive(1, 1, 'h02, 'h03); cycle();
      chk("post_rst_add", 32'(result), 32'h0005);
      drive(0, 0, 0, 0);       cycle();

      // Random traffic, MUL-biased
      for (int i = 0; i < 400; i++) begin
         int unsigned o;
         o = ($urandom_range(0, 3) == 0) ? 4 : $urandom_range(0, 7);
         drive($urandom_range(0, 3) != 0, o, $urandom_range(0, 255), $urandom_range(0, 255));
         cycle();
      end
      drive(0, 0, 0, 0);
      repeat (LAT + 1) cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
